magma_key_sched: RTL and testbench

Upstream key-schedule stage for the Magma (GOST 28147-89) round core. It accepts a 256-bit key as eight 32-bit words over a write handshake and stores them. On request, it streams the 32 round keys for encryption or decryption, one per valid/ready transfer, to the round datapath. It replaces any hard-coded key storage and iteration-key table in the core.

---
 rtl/magma_key_sched_if.sv | 28 ++
 rtl/magma_key_sched.sv | 144 ++++++++++++++
 tb/tb_magma_key_sched.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/magma_key_sched_if.sv
// Key-load and round-key streaming bundle between the Magma key schedule and its neighbours.
// The master side loads key words and consumes round keys; the slave side is the key schedule.
interface magma_key_sched_if #(
   parameter int WORD_W = 32
);
   logic              key_wr;
   logic [WORD_W-1:0] key_word;
   logic              key_ready;
   logic              key_loaded;
   logic              start;
   logic              decrypt;
   logic              rk_valid;
   logic              rk_ready;
   logic [WORD_W-1:0] rk;
   logic [4:0]        rk_idx;
   logic              rk_last;
   logic              busy;

   modport master (
      output key_wr, key_word, start, decrypt, rk_ready,
      input  key_ready, key_loaded, rk_valid, rk, rk_idx, rk_last, busy
   );

   modport slave (
      input  key_wr, key_word, start, decrypt, rk_ready,
      output key_ready, key_loaded, rk_valid, rk, rk_idx, rk_last, busy
   );
endinterface

// File: rtl/magma_key_sched.sv
// Magma (GOST 28147-89) key schedule: stores a 256-bit key as 8 words and
// streams the 32 encrypt or decrypt round keys over a valid/ready handshake.
module magma_key_sched #(
   parameter int WORD_W = 32,
   parameter int NWORDS = 8
) (
   input logic              clk,
   input logic              rst,
   magma_key_sched_if.slave ks
);

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_LOADING,
      ST_KEYED,
      ST_STREAM
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        wcnt_q, wcnt_d;
   logic [4:0]        ridx_q, ridx_d;
   logic [4:0]        ridx_nxt;
   logic              dir_q, dir_d;
   logic [WORD_W-1:0] key_mem_q [NWORDS];
   logic [WORD_W-1:0] key_mem_d [NWORDS];
   logic              key_ready_q, key_ready_d;
   logic              key_loaded_q, key_loaded_d;
   logic              rk_valid_q, rk_valid_d;
   logic [WORD_W-1:0] rk_q, rk_d;
   logic              rk_last_q, rk_last_d;
   logic              busy_q, busy_d;

   // Encrypt runs K0..K7 three times then K7..K0; decrypt runs K0..K7 once then
   // K7..K0 three times. Reversal within a group of 8 is just the inverted low bits.
   function automatic logic [2:0] sched_slot(input logic dir, input logic [4:0] idx);
      logic rev;
      rev = dir ? (idx[4:3] != 2'd0) : (idx[4:3] == 2'd3);
      return rev ? ~idx[2:0] : idx[2:0];
   endfunction

   assign ridx_nxt = ridx_q + 5'd1;

   always_comb begin
      state_d      = state_q;
      wcnt_d       = wcnt_q;
      ridx_d       = ridx_q;
      dir_d        = dir_q;
      key_mem_d    = key_mem_q;
      key_loaded_d = key_loaded_q;
      rk_valid_d   = rk_valid_q;
      rk_d         = rk_q;
      rk_last_d    = rk_last_q;
      busy_d       = busy_q;

      case (state_q)
         ST_EMPTY, ST_LOADING: begin
            if (ks.key_wr) begin
               key_mem_d[wcnt_q] = ks.key_word;
               wcnt_d            = wcnt_q + 3'd1;
               if (wcnt_q == 3'd7) begin
                  state_d      = ST_KEYED;
                  key_loaded_d = 1'b1;
               end else begin
                  state_d = ST_LOADING;
               end
            end
         end

         ST_KEYED: begin
            // A write here starts a full reload and takes priority over start.
            if (ks.key_wr) begin
               key_mem_d[0] = ks.key_word;
               wcnt_d       = 3'd1;
               key_loaded_d = 1'b0;
               state_d      = ST_LOADING;
            end else if (ks.start) begin
               dir_d      = ks.decrypt;
               ridx_d     = 5'd0;
               rk_d       = key_mem_q[sched_slot(ks.decrypt, 5'd0)];
               rk_last_d  = 1'b0;
               rk_valid_d = 1'b1;
               busy_d     = 1'b1;
               state_d    = ST_STREAM;
            end
         end

         ST_STREAM: begin
            if (ks.rk_ready) begin
               if (ridx_q == 5'd31) begin
                  rk_valid_d = 1'b0;
                  busy_d     = 1'b0;
                  rk_last_d  = 1'b0;
                  state_d    = ST_KEYED;
               end else begin
                  ridx_d    = ridx_nxt;
                  rk_d      = key_mem_q[sched_slot(dir_q, ridx_nxt)];
                  rk_last_d = (ridx_nxt == 5'd31);
               end
            end
         end

         default: state_d = ST_EMPTY;
      endcase

      key_ready_d = (state_d != ST_STREAM);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_EMPTY;
         wcnt_q       <= 3'd0;
         ridx_q       <= 5'd0;
         dir_q        <= 1'b0;
         key_mem_q    <= '{default: '0};
         key_ready_q  <= 1'b1;
         key_loaded_q <= 1'b0;
         rk_valid_q   <= 1'b0;
         rk_q         <= '0;
         rk_last_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wcnt_q       <= wcnt_d;
         ridx_q       <= ridx_d;
         dir_q        <= dir_d;
         key_mem_q    <= key_mem_d;
         key_ready_q  <= key_ready_d;
         key_loaded_q <= key_loaded_d;
         rk_valid_q   <= rk_valid_d;
         rk_q         <= rk_d;
         rk_last_q    <= rk_last_d;
         busy_q       <= busy_d;
      end
   end

   assign ks.key_ready  = key_ready_q;
   assign ks.key_loaded = key_loaded_q;
   assign ks.rk_valid   = rk_valid_q;
   assign ks.rk         = rk_q;
   assign ks.rk_idx     = ridx_q;
   assign ks.rk_last    = rk_last_q;
   assign ks.busy       = busy_q;

endmodule

// File: tb/tb_magma_key_sched.sv
// Directed bench for magma_key_sched: key load, encrypt/decrypt schedules,
// backpressure, reload/start collision and mid-stream reset.
module tb_magma_key_sched;

   logic clk;
   logic rst;

   magma_key_sched_if #(.WORD_W(32)) ks_if ();

   magma_key_sched #(.WORD_W(32), .NWORDS(8)) dut (
      .clk(clk),
      .rst(rst),
      .ks (ks_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        dir;
      int          idx;
      logic [31:0] exp;
   } spot_t;

   int          n_checks;
   int          n_errors;
   logic [31:0] keyw   [8];
   logic [31:0] cap    [32];
   logic [31:0] enc_rk [32];
   logic [31:0] dec_rk [32];
   spot_t       spots  [11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] model_key(input logic d, input int i);
      if (!d) return (i < 24) ? keyw[i % 8] : keyw[31 - i];
      else    return (i < 8)  ? keyw[i]     : keyw[7 - (i % 8)];
   endfunction

   task automatic write_word(input logic [31:0] w, input logic exp_loaded);
      ks_if.key_wr   = 1'b1;
      ks_if.key_word = w;
      chk("key_ready_load", 32'(ks_if.key_ready), 32'd1);
      tick();
      chk("key_loaded", 32'(ks_if.key_loaded), 32'(exp_loaded));
   endtask

   task automatic run_stream(input logic d, input bit stall, input bit poke);
      int          cnt;
      int          cyc;
      int          vcyc;
      bit          rdy;
      bit          stalled;
      logic [31:0] prk;
      logic [4:0]  pidx;
      for (int i = 0; i < 32; i++) cap[i] = 32'h0;
      ks_if.decrypt = d;
      ks_if.start   = 1'b1;
      tick();
      ks_if.start = 1'b0;
      chk("first_valid", 32'(ks_if.rk_valid), 32'd1);
      chk("busy_stream", 32'(ks_if.busy), 32'd1);
      cnt  = 0;
      cyc  = 0;
      vcyc = 0;
      prk  = 32'h0;
      pidx = 5'd0;
      while (cnt < 32 && cyc < 400) begin
         if (!stall)       rdy = 1'b1;
         else if (cyc < 16) rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
         else              rdy = ($urandom_range(0, 1) == 1);
         ks_if.rk_ready = rdy;
         ks_if.key_wr   = poke && !rdy;
         ks_if.key_word = 32'hDEADBEEF;
         if (poke && !rdy) chk("key_ready_stream", 32'(ks_if.key_ready), 32'd0);
         if (ks_if.rk_valid) vcyc++;
         stalled = 1'b0;
         if (ks_if.rk_valid && rdy) begin
            chk("rk_idx", 32'(ks_if.rk_idx), 32'(cnt));
            chk("rk_last", 32'(ks_if.rk_last), 32'(cnt == 31));
            cap[cnt] = ks_if.rk;
            cnt++;
         end else if (ks_if.rk_valid) begin
            stalled = 1'b1;
            prk     = ks_if.rk;
            pidx    = ks_if.rk_idx;
         end
         tick();
         cyc++;
         if (stalled) begin
            chk("stall_rk", ks_if.rk, prk);
            chk("stall_idx", 32'(ks_if.rk_idx), 32'(pidx));
         end
      end
      ks_if.key_wr   = 1'b0;
      ks_if.rk_ready = 1'b0;
      chk("xfer_count", 32'(cnt), 32'd32);
      if (!stall) chk("valid_cycles", 32'(vcyc), 32'd32);
      chk("end_valid", 32'(ks_if.rk_valid), 32'd0);
      chk("end_busy", 32'(ks_if.busy), 32'd0);
      chk("end_last", 32'(ks_if.rk_last), 32'd0);
      chk("end_key_ready", 32'(ks_if.key_ready), 32'd1);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      keyw = '{32'hFFEEDDCC, 32'hBBAA9988, 32'h77665544, 32'h33221100,
               32'hF0F1F2F3, 32'hF4F5F6F7, 32'hF8F9FAFB, 32'hFCFDFEFF};
      spots[0]  = '{1'b0, 0,  32'hFFEEDDCC};
      spots[1]  = '{1'b0, 7,  32'hFCFDFEFF};
      spots[2]  = '{1'b0, 8,  32'hFFEEDDCC};
      spots[3]  = '{1'b0, 23, 32'hFCFDFEFF};
      spots[4]  = '{1'b0, 24, 32'hFCFDFEFF};
      spots[5]  = '{1'b0, 31, 32'hFFEEDDCC};
      spots[6]  = '{1'b1, 0,  32'hFFEEDDCC};
      spots[7]  = '{1'b1, 7,  32'hFCFDFEFF};
      spots[8]  = '{1'b1, 8,  32'hFCFDFEFF};
      spots[9]  = '{1'b1, 15, 32'hFFEEDDCC};
      spots[10] = '{1'b1, 31, 32'hFFEEDDCC};

      ks_if.key_wr   = 1'b0;
      ks_if.key_word = 32'h0;
      ks_if.start    = 1'b0;
      ks_if.decrypt  = 1'b0;
      ks_if.rk_ready = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      chk("rst_key_ready", 32'(ks_if.key_ready), 32'd1);
      chk("rst_key_loaded", 32'(ks_if.key_loaded), 32'd0);
      chk("rst_rk_valid", 32'(ks_if.rk_valid), 32'd0);
      chk("rst_rk", ks_if.rk, 32'd0);
      chk("rst_rk_idx", 32'(ks_if.rk_idx), 32'd0);
      chk("rst_rk_last", 32'(ks_if.rk_last), 32'd0);
      chk("rst_busy", 32'(ks_if.busy), 32'd0);
      rst = 1'b0;

      // Start before any key is loaded must be ignored.
      ks_if.start = 1'b1;
      tick();
      ks_if.start = 1'b0;
      tick();
      chk("start_empty", 32'(ks_if.rk_valid), 32'd0);

      for (int i = 0; i < 8; i++) write_word(keyw[i], i == 7);
      ks_if.key_wr = 1'b0;

      run_stream(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 32; i++) enc_rk[i] = cap[i];
      run_stream(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 32; i++) dec_rk[i] = cap[i];

      for (int s = 0; s < 11; s++)
         chk($sformatf("spot_d%0d_i%0d", spots[s].dir, spots[s].idx),
             spots[s].dir ? dec_rk[spots[s].idx] : enc_rk[spots[s].idx], spots[s].exp);
      for (int i = 0; i < 32; i++) begin
         chk($sformatf("enc_model_%0d", i), enc_rk[i], model_key(1'b0, i));
         chk($sformatf("dec_model_%0d", i), dec_rk[i], model_key(1'b1, i));
      end

      run_stream(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 32; i++) chk($sformatf("stall_seq_%0d", i), cap[i], enc_rk[i]);

      // Reload colliding with start: the write wins, no stream begins.
      ks_if.key_wr   = 1'b1;
      ks_if.key_word = 32'h11111111;
      ks_if.start    = 1'b1;
      ks_if.decrypt  = 1'b0;
      tick();
      ks_if.key_wr = 1'b0;
      ks_if.start  = 1'b0;
      chk("coll_valid", 32'(ks_if.rk_valid), 32'd0);
      chk("coll_busy", 32'(ks_if.busy), 32'd0);
      chk("coll_loaded", 32'(ks_if.key_loaded), 32'd0);
      tick();
      chk("coll_valid2", 32'(ks_if.rk_valid), 32'd0);
      keyw[0] = 32'h11111111;
      for (int i = 1; i < 8; i++) begin
         keyw[i] = {4{8'(8'h11 * (i + 1))}};
         write_word(keyw[i], i == 7);
      end
      ks_if.key_wr = 1'b0;
      run_stream(1'b0, 1'b0, 1'b0);
      chk("reload_idx0", cap[0], 32'h11111111);
      chk("reload_idx24", cap[24], 32'h88888888);
      for (int i = 0; i < 32; i++) chk($sformatf("reload_model_%0d", i), cap[i], model_key(1'b0, i));

      // Reset in the middle of a stream.
      begin
         bit found;
         found = 1'b0;
         ks_if.decrypt = 1'b0;
         ks_if.start   = 1'b1;
         tick();
         ks_if.start    = 1'b0;
         ks_if.rk_ready = 1'b1;
         for (int c = 0; c < 50 && !found; c++) begin
            if (ks_if.rk_valid && ks_if.rk_idx == 5'd10) found = 1'b1;
            else tick();
         end
         chk("reach_idx10", 32'(found), 32'd1);
         rst = 1'b1;
         tick();
         rst = 1'b0;
         chk("mid_rst_valid", 32'(ks_if.rk_valid), 32'd0);
         chk("mid_rst_busy", 32'(ks_if.busy), 32'd0);
         chk("mid_rst_loaded", 32'(ks_if.key_loaded), 32'd0);
         ks_if.start = 1'b1;
         tick();
         ks_if.start = 1'b0;
         for (int c = 0; c < 5; c++) begin
            chk("post_rst_no_valid", 32'(ks_if.rk_valid), 32'd0);
            tick();
         end
         ks_if.rk_ready = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
